// File: rtl/jesd204_rx_cgs_align.sv
// JESD204B per-lane receive front end: code-group sync state machine, SYNC~ generation,
// and alignment of the 2-octet SERDES stream into 32-bit beats starting at user data.
module jesd204_rx_cgs_align #(
   parameter int CGS_K_COUNT     = 4,
   parameter int CHECK_ERR_LIMIT = 3,
   parameter int ERR_CNT_WIDTH   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     phy_ready,
   input  logic [15:0]              rx_data,
   input  logic [1:0]               rx_charisk,
   input  logic [1:0]               rx_disperr,
   input  logic [1:0]               rx_notintable,
   output logic                     sync_n,
   output logic                     lane_synced,
   output logic [31:0]              data_out,
   output logic [3:0]               charisk_out,
   output logic                     data_valid,
   output logic                     first_beat,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   localparam int KW = $clog2(CGS_K_COUNT + 1);
   localparam int IW = $clog2(CHECK_ERR_LIMIT + 1);

   typedef enum logic [1:0] {
      CS_INIT  = 2'd0,
      CS_DATA  = 2'd1,
      CS_CHECK = 2'd2
   } cs_t;

   typedef struct packed {
      cs_t                     st;
      logic [KW-1:0]           kcnt;
      logic [IW-1:0]           icnt;
      logic [1:0]              vcnt;
      logic                    lock;
      logic                    first;
      logic [1:0]              pcnt;
      logic [23:0]             pbuf;
      logic [2:0]              pk;
      logic [ERR_CNT_WIDTH-1:0] err;
      logic                    beat;
      logic                    bfirst;
      logic                    kill;
      logic [31:0]             bdata;
      logic [3:0]              bk;
   } ctx_t;

   ctx_t                     r_ctx;
   ctx_t                     w_c0;
   ctx_t                     w_c1;
   ctx_t                     w_c2;
   ctx_t                     w_nxt;
   logic                     w_emit;
   logic                     r_sync_n;
   logic                     r_lane_synced;
   logic [31:0]              r_data_out;
   logic [3:0]               r_charisk_out;
   logic                     r_data_valid;
   logic                     r_first_beat;

   // One octet through lock/pack, error count and CGS state; beat fields report a completed beat.
   function automatic ctx_t step(input ctx_t c, input logic [7:0] d, input logic k,
                                 input logic de, input logic nt);
      ctx_t n;
      logic v;
      logic vk;
      logic pack;
      n    = c;
      v    = ~de & ~nt;
      vk   = v & k & (d == 8'hBC);
      pack = 1'b0;
      if (c.st == CS_DATA && !c.lock && !vk) begin
         n.lock  = 1'b1;
         n.first = 1'b1;
         pack    = 1'b1;
      end else if (c.st != CS_INIT && c.lock) begin
         pack = 1'b1;
      end else begin
         pack = 1'b0;
      end
      if (pack) begin
         case (c.pcnt)
            2'd0: begin n.pbuf[7:0]   = d; n.pk[0] = k; n.pcnt = 2'd1; end
            2'd1: begin n.pbuf[15:8]  = d; n.pk[1] = k; n.pcnt = 2'd2; end
            2'd2: begin n.pbuf[23:16] = d; n.pk[2] = k; n.pcnt = 2'd3; end
            default: begin
               n.beat   = 1'b1;
               n.bfirst = n.first;
               n.first  = 1'b0;
               n.bdata  = {d, c.pbuf};
               n.bk     = {k, c.pk};
               n.pcnt   = 2'd0;
            end
         endcase
      end
      if (!v && c.st != CS_INIT && c.err != {ERR_CNT_WIDTH{1'b1}}) begin
         n.err = c.err + ERR_CNT_WIDTH'(1);
      end
      case (c.st)
         CS_INIT: begin
            if (!vk) begin
               n.kcnt = '0;
            end else if (c.kcnt == KW'(CGS_K_COUNT - 1)) begin
               n.st   = CS_DATA;
               n.kcnt = '0;
               n.lock = 1'b0;
            end else begin
               n.kcnt = c.kcnt + KW'(1);
            end
         end
         CS_DATA: begin
            if (!v) begin
               n.st   = CS_CHECK;
               n.icnt = IW'(1);
               n.vcnt = 2'd0;
            end
         end
         CS_CHECK: begin
            if (!v && c.icnt == IW'(CHECK_ERR_LIMIT - 1)) begin
               // Losing sync drops any partial beat, including one this octet just completed.
               n.st    = CS_INIT;
               n.kcnt  = '0;
               n.icnt  = '0;
               n.vcnt  = 2'd0;
               n.lock  = 1'b0;
               n.first = 1'b0;
               n.pcnt  = 2'd0;
               n.kill  = 1'b1;
            end else if (!v) begin
               n.icnt = c.icnt + IW'(1);
               n.vcnt = 2'd0;
            end else if (c.vcnt == 2'd3) begin
               n.vcnt = 2'd0;
               n.icnt = c.icnt - IW'(1);
               if (c.icnt == IW'(1)) begin
                  n.st = CS_DATA;
               end
            end else begin
               n.vcnt = c.vcnt + 2'd1;
            end
         end
         default: begin
            n.st = CS_INIT;
         end
      endcase
      return n;
   endfunction

   // Next-state: octet 0 then octet 1; a dropped PHY forces CS_INIT but keeps the error count.
   always_comb begin
      w_c0        = r_ctx;
      w_c0.beat   = 1'b0;
      w_c0.bfirst = 1'b0;
      w_c0.kill   = 1'b0;
      w_c0.bdata  = 32'h0;
      w_c0.bk     = 4'h0;
      w_c1        = step(w_c0, rx_data[7:0], rx_charisk[0], rx_disperr[0], rx_notintable[0]);
      w_c2        = step(w_c1, rx_data[15:8], rx_charisk[1], rx_disperr[1], rx_notintable[1]);
      w_nxt       = w_c2;
      w_emit      = 1'b0;
      if (!phy_ready) begin
         w_nxt     = '0;
         w_nxt.err = r_ctx.err;
         w_emit    = 1'b0;
      end else begin
         w_nxt  = w_c2;
         w_emit = w_c2.beat & ~w_c2.kill;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctx         <= '0;
         r_sync_n      <= 1'b0;
         r_lane_synced <= 1'b0;
         r_data_out    <= 32'h0;
         r_charisk_out <= 4'h0;
         r_data_valid  <= 1'b0;
         r_first_beat  <= 1'b0;
      end else begin
         r_ctx         <= w_nxt;
         r_sync_n      <= (w_nxt.st != CS_INIT);
         r_lane_synced <= (w_nxt.st == CS_DATA) || (w_nxt.st == CS_CHECK);
         r_data_valid  <= w_emit;
         r_first_beat  <= w_emit & w_c2.bfirst;
         if (w_emit) begin
            r_data_out    <= w_c2.bdata;
            r_charisk_out <= w_c2.bk;
         end
      end
   end

   assign sync_n      = r_sync_n;
   assign lane_synced = r_lane_synced;
   assign data_out    = r_data_out;
   assign charisk_out = r_charisk_out;
   assign data_valid  = r_data_valid;
   assign first_beat  = r_first_beat;
   assign err_count   = r_ctx.err;

endmodule

// File: tb/tb_jesd204_rx_cgs_align.sv
// Directed bench for jesd204_rx_cgs_align: CGS, lock/packing, CHECK recovery, PHY drop,
// and error-counter saturation on a narrow-counter second instance.
module tb_jesd204_rx_cgs_align;

   logic        clk;
   logic        reset;
   logic        phy_ready;
   logic [15:0] rx_data;
   logic [1:0]  rx_charisk;
   logic [1:0]  rx_disperr;
   logic [1:0]  rx_notintable;

   logic        sync_n, lane_synced, data_valid, first_beat;
   logic [31:0] data_out;
   logic [3:0]  charisk_out;
   logic [15:0] err_count;

   logic        e_sync_n, e_lane_synced, e_data_valid, e_first_beat;
   logic [31:0] e_data_out;
   logic [3:0]  e_charisk_out;
   logic [1:0]  e_err_count;

   int n_total = 0;
   int n_bad   = 0;

   jesd204_rx_cgs_align dut (
      .clk(clk), .reset(reset), .phy_ready(phy_ready),
      .rx_data(rx_data), .rx_charisk(rx_charisk), .rx_disperr(rx_disperr),
      .rx_notintable(rx_notintable),
      .sync_n(sync_n), .lane_synced(lane_synced), .data_out(data_out),
      .charisk_out(charisk_out), .data_valid(data_valid), .first_beat(first_beat),
      .err_count(err_count)
   );

   jesd204_rx_cgs_align #(.ERR_CNT_WIDTH(2)) dut_e (
      .clk(clk), .reset(reset), .phy_ready(phy_ready),
      .rx_data(rx_data), .rx_charisk(rx_charisk), .rx_disperr(rx_disperr),
      .rx_notintable(rx_notintable),
      .sync_n(e_sync_n), .lane_synced(e_lane_synced), .data_out(e_data_out),
      .charisk_out(e_charisk_out), .data_valid(e_data_valid), .first_beat(e_first_beat),
      .err_count(e_err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic [1:0] k, input logic [1:0] de);
      rx_data       = d;
      rx_charisk    = k;
      rx_disperr    = de;
      rx_notintable = 2'b00;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                           input logic fb);
      chk_eq({tag, "_dv"}, {31'd0, data_valid}, 32'd1);
      chk_eq({tag, "_fb"}, {31'd0, first_beat}, {31'd0, fb});
      chk_eq({tag, "_data"}, data_out, d);
      chk_eq({tag, "_k"}, {28'd0, charisk_out}, {28'd0, k});
   endtask

   initial begin
      reset     = 1'b1;
      phy_ready = 1'b1;
      send(16'h0000, 2'b00, 2'b00);
      send(16'h0000, 2'b00, 2'b00);
      chk_eq("rst_sync_n", {31'd0, sync_n}, 32'd0);
      chk_eq("rst_lane", {31'd0, lane_synced}, 32'd0);
      chk_eq("rst_data", data_out, 32'h0);
      chk_eq("rst_k", {28'd0, charisk_out}, 32'd0);
      chk_eq("rst_dv", {31'd0, data_valid}, 32'd0);
      chk_eq("rst_fb", {31'd0, first_beat}, 32'd0);
      chk_eq("rst_err", {16'd0, err_count}, 32'd0);
      reset = 1'b0;

      // CGS: four /K/ over two words
      send(16'hBCBC, 2'b11, 2'b00);
      chk_eq("cgs1_sync_n", {31'd0, sync_n}, 32'd0);
      send(16'hBCBC, 2'b11, 2'b00);
      chk_eq("cgs2_sync_n", {31'd0, sync_n}, 32'd1);
      chk_eq("cgs2_lane", {31'd0, lane_synced}, 32'd1);
      chk_eq("cgs2_dv", {31'd0, data_valid}, 32'd0);

      // lock on the 0x1C control octet in the upper half
      send(16'h1CBC, 2'b11, 2'b00);
      chk_eq("lk1_dv", {31'd0, data_valid}, 32'd0);
      send(16'h0201, 2'b00, 2'b00);
      chk_eq("lk2_dv", {31'd0, data_valid}, 32'd0);
      send(16'h0403, 2'b00, 2'b00);
      chk_beat("beat0", 32'h0302011C, 4'b0001, 1'b1);
      send(16'h0605, 2'b00, 2'b00);
      chk_eq("gap_dv", {31'd0, data_valid}, 32'd0);
      chk_eq("hold_data", data_out, 32'h0302011C);
      send(16'h0807, 2'b00, 2'b00);
      chk_beat("beat1", 32'h07060504, 4'b0000, 1'b0);

      // two invalid octets, eight valid: recover to CS_DATA without losing sync
      send(16'h0A09, 2'b00, 2'b11);
      chk_eq("chk1_dv", {31'd0, data_valid}, 32'd0);
      chk_eq("chk1_sync", {31'd0, sync_n}, 32'd1);
      chk_eq("chk1_err", {16'd0, err_count}, 32'd2);
      chk_eq("chk1_errE", {30'd0, e_err_count}, 32'd2);
      send(16'h0C0B, 2'b00, 2'b00);
      chk_beat("beat2", 32'h0B0A0908, 4'b0000, 1'b0);
      send(16'h0E0D, 2'b00, 2'b00);
      chk_eq("chk3_sync", {31'd0, sync_n}, 32'd1);
      send(16'h100F, 2'b00, 2'b00);
      chk_beat("beat3", 32'h0F0E0D0C, 4'b0000, 1'b0);
      send(16'h1211, 2'b00, 2'b00);
      chk_eq("chk5_sync", {31'd0, sync_n}, 32'd1);
      // back in CS_DATA, so two more invalid octets must not drop sync
      send(16'h1413, 2'b00, 2'b11);
      chk_beat("beat4", 32'h13121110, 4'b0000, 1'b0);
      chk_eq("chk6_sync", {31'd0, sync_n}, 32'd1);
      chk_eq("chk6_err", {16'd0, err_count}, 32'd4);
      chk_eq("chk6_errE", {30'd0, e_err_count}, 32'd3);
      send(16'h1615, 2'b00, 2'b01);
      chk_eq("loss_sync", {31'd0, sync_n}, 32'd0);
      chk_eq("loss_lane", {31'd0, lane_synced}, 32'd0);
      chk_eq("loss_dv", {31'd0, data_valid}, 32'd0);
      chk_eq("loss_err", {16'd0, err_count}, 32'd5);

      // re-CGS, partial lock, then PHY drop mid-beat
      send(16'hBCBC, 2'b11, 2'b00);
      send(16'hBCBC, 2'b11, 2'b00);
      chk_eq("recgs_sync", {31'd0, sync_n}, 32'd1);
      send(16'h2221, 2'b00, 2'b00);
      phy_ready = 1'b0;
      send(16'h2423, 2'b00, 2'b11);
      chk_eq("phy_sync", {31'd0, sync_n}, 32'd0);
      chk_eq("phy_lane", {31'd0, lane_synced}, 32'd0);
      chk_eq("phy_dv", {31'd0, data_valid}, 32'd0);
      chk_eq("phy_err", {16'd0, err_count}, 32'd5);
      phy_ready = 1'b1;
      send(16'hBCBC, 2'b11, 2'b00);
      send(16'hBCBC, 2'b11, 2'b00);
      chk_eq("phy_resync", {31'd0, sync_n}, 32'd1);
      send(16'h5150, 2'b00, 2'b00);
      send(16'h5352, 2'b00, 2'b00);
      chk_beat("rebeat0", 32'h53525150, 4'b0000, 1'b1);

      // three consecutive disparity errors from CS_DATA
      send(16'h5554, 2'b00, 2'b11);
      chk_eq("de2_sync", {31'd0, sync_n}, 32'd1);
      chk_eq("de2_err", {16'd0, err_count}, 32'd7);
      send(16'h5756, 2'b00, 2'b01);
      chk_eq("de3_sync", {31'd0, sync_n}, 32'd0);
      chk_eq("de3_dv", {31'd0, data_valid}, 32'd0);
      chk_eq("de3_err", {16'd0, err_count}, 32'd8);
      chk_eq("de3_errE", {30'd0, e_err_count}, 32'd3);

      // only reset clears the error counters
      reset = 1'b1;
      send(16'h0000, 2'b00, 2'b00);
      chk_eq("rst2_err", {16'd0, err_count}, 32'd0);
      chk_eq("rst2_errE", {30'd0, e_err_count}, 32'd0);
      chk_eq("rst2_sync", {31'd0, sync_n}, 32'd0);
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/jesd204_rx_cgs_align.md
# jesd204_rx_cgs_align

Per-lane JESD204B 8b/10b receive front end. It sits between the DCUA channel-0 receive outputs and the JESD204 RX link layer, both running on the recovered link clock. It runs the code-group synchronization (CGS) state machine and drives the active-low SYNC~ request. After sync it aligns the 2-octet-per-cycle SERDES stream to the start of user data and packs it into 32-bit beats (DATA_PATH_WIDTH = 4).

## Interface
Parameters:
- CGS_K_COUNT, 4: consecutive valid /K/ (K28.5) octets required to leave CS_INIT.
- CHECK_ERR_LIMIT, 3: invalid-octet count in CS_CHECK that forces CS_INIT.
- ERR_CNT_WIDTH, 16: width of the saturating error counter.

Ports:
- clk  in  1  recovered link clock (CH0_FF_RX_PCLK); the only clock.
- reset  in  1  synchronous, active-high.
- phy_ready  in  1  SERDES locked; low forces CS_INIT.
- rx_data  in  16  octet 0 = [7:0] (earlier in time), octet 1 = [15:8].
- rx_charisk  in  2  per-octet K flag.
- rx_disperr  in  2  per-octet disparity error.
- rx_notintable  in  2  per-octet code violation.
- sync_n  out  1  JESD SYNC~; 0 requests CGS.
- lane_synced  out  1  state is CS_DATA or CS_CHECK.
- data_out  out  32  aligned beat; [7:0] is the earliest octet.
- charisk_out  out  4  K flags matching data_out octets.
- data_valid  out  1  beat strobe.
- first_beat  out  1  qualifies the first beat after each lock.
- err_count  out  ERR_CNT_WIDTH  saturating count of invalid octets seen outside CS_INIT.

## Operation
- Valid octet: disperr = 0 and notintable = 0. Valid /K/: valid octet with k = 1 and data = 0xBC.
- Octets are evaluated in stream order: octet 0, then octet 1. The state and counters that result from octet 0 govern octet 1. All registers update once per clock with the result after octet 1.
- CS_INIT: kcnt increments on each valid /K/. Any other octet clears kcnt. When kcnt reaches CGS_K_COUNT, go to CS_DATA and clear the lock.
- CS_DATA: an invalid octet moves to CS_CHECK with icnt = 1, vcnt = 0.
- CS_CHECK:
  - Invalid octet: icnt++, vcnt = 0. If icnt reaches CHECK_ERR_LIMIT, go to CS_INIT and clear kcnt.
  - Valid octet: vcnt++. When vcnt reaches 4: vcnt = 0, icnt--. If icnt reaches 0, go to CS_DATA.
- sync_n and lane_synced are registered with the state: sync_n = 0 in CS_INIT, 1 otherwise.
- Lock:
  - The lock point s is the stream index of the first octet that is not a valid /K/, seen while in CS_DATA with no lock held.
  - Beat j carries octets o[s+4j .. s+4j+3], with o[s+4j] in data_out[7:0].
  - Packing continues through CS_CHECK. Invalid octets are packed as received.
- Entering CS_INIT (by the state machine, phy_ready = 0, or reset):
  - clears the lock and the partial beat;
  - data_valid = 0.
  - The next CS_DATA entry re-locks at a new s.
- err_count increments by 0, 1 or 2 per cycle: once for each invalid octet evaluated in CS_DATA or CS_CHECK. It saturates at all-ones. It is cleared only by reset, not by phy_ready.

## Timing
- Reset values: sync_n = 0, lane_synced = 0, data_out = 0, charisk_out = 0, data_valid = 0, first_beat = 0, err_count = 0, state CS_INIT.
- phy_ready = 0 at edge N: at edge N the state becomes CS_INIT and sync_n = 0. The input word at that edge is ignored.
- sync_n rises at the same edge that registers the CS_DATA transition. The 4th /K/ is in the input word sampled at edge N; sync_n = 1 after edge N.
- Beat latency: data_valid = 1 for exactly one cycle, after the edge that samples the word containing o[s+4j+3]. data_out and charisk_out are held until the next beat.
- Steady state: one beat every 2 cycles.
- first_beat = 1 only together with data_valid for beat 0.

## Test plan
- Reset, phy_ready = 1, rx_data = 0xBCBC, charisk = 2'b11 for 2 cycles -> sync_n = 1 and lane_synced = 1 after the 2nd edge; no data_valid.
- After sync, feed:
  - {hi = 0x1C k, lo = 0xBC k}
  - {0x02, 0x01}
  - {0x04, 0x03}
  - -> after the 3rd edge: data_valid = 1, first_beat = 1, data_out = 0x0302011C, charisk_out = 4'b0001.
  - Next beat: 0x.. 0x..0504 continues with no gap.
- In CS_DATA, 3 consecutive octets with disperr = 1 -> CS_INIT, sync_n = 0 after that edge, data_valid stays 0, err_count = 3.
- In CS_DATA, 2 invalid octets then 8 valid octets -> sync_n stays 1 throughout; state returns to CS_DATA after the 8th valid octet; beats continue uninterrupted.
- phy_ready dropped mid-beat in CS_DATA -> sync_n = 0 and data_valid = 0 next cycle; err_count retained. Re-CGS relocks with first_beat = 1 again.
- ERR_CNT_WIDTH = 2, 6 invalid octets spread over CHECK/DATA re-entries -> err_count saturates at 3. Only reset returns it to 0.
